// File: rtl/axis_mag_avg.sv
// Per-channel windowed average of a packed two's complement sample stream,
// emitted as saturating sign-magnitude or two's complement after two stages.
module axis_mag_avg #(
    parameter int WIDTH    = 10,
    parameter int NCH      = 3,
    parameter int AVG_LOG2 = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   IN_VALID,
    input  logic [NCH*WIDTH-1:0]   IN_DATA,
    input  logic                   CLR,
    input  logic                   MODE,
    output logic                   OUT_VALID,
    output logic [NCH*WIDTH-1:0]   OUT_DATA,
    output logic [NCH-1:0]         OUT_OVF
);
    localparam int AW = WIDTH + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0]    LAST     = CW'((1 << AVG_LOG2) - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CW-1:0]          cnt;
    logic                   win_last;
    logic                   s1_valid;
    logic                   fire;
    logic signed [AW-1:0]   acc      [NCH];
    logic signed [AW-1:0]   sum      [NCH];
    logic [WIDTH-1:0]       avg_next [NCH];
    logic [WIDTH-1:0]       avg      [NCH];
    logic [WIDTH-1:0]       neg      [NCH];
    logic [NCH*WIDTH-1:0]   enc_data;
    logic [NCH-1:0]         enc_ovf;

    assign win_last = (cnt == LAST);
    // CLR cancels a result waiting in stage 1, so stage 2 never fires alongside it
    assign fire = s1_valid && !CLR;

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            sum[c] = AW'($signed(IN_DATA[c*WIDTH +: WIDTH]));
            if (cnt != '0) begin
                sum[c] = acc[c] + sum[c];
            end
            avg_next[c] = WIDTH'(sum[c] >>> AVG_LOG2);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                acc[c] <= '0;
                avg[c] <= '0;
            end
        end else begin
            s1_valid <= 1'b0;
            if (CLR) begin
                cnt <= '0;
                for (int unsigned c = 0; c < NCH; c++) begin
                    acc[c] <= '0;
                end
            end else if (IN_VALID) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    acc[c] <= sum[c];
                end
                cnt <= win_last ? '0 : cnt + CW'(1);
                if (win_last) begin
                    s1_valid <= 1'b1;
                    for (int unsigned c = 0; c < NCH; c++) begin
                        avg[c] <= avg_next[c];
                    end
                end
            end
        end
    end

    // Negative non-extreme averages have |a| < 2^(WIDTH-1), so OR-ing in the sign bit is exact
    always_comb begin
        enc_data = '0;
        enc_ovf  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            neg[c] = '0 - avg[c];
            enc_data[c*WIDTH +: WIDTH] = avg[c];
            if (!MODE && avg[c][WIDTH-1]) begin
                if (avg[c] == MOST_NEG) begin
                    enc_data[c*WIDTH +: WIDTH] = '1;
                    enc_ovf[c] = 1'b1;
                end else begin
                    enc_data[c*WIDTH +: WIDTH] = MOST_NEG | neg[c];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_OVF   <= '0;
        end else begin
            OUT_VALID <= fire;
            if (fire) begin
                OUT_DATA <= enc_data;
                OUT_OVF  <= enc_ovf;
            end
        end
    end

endmodule

// File: tb/tb_axis_mag_avg.sv
// Bench for axis_mag_avg: two instances (window 4 and window 1) share stimulus
// and are checked every cycle against a sum-and-divide reference model.
module tb_axis_mag_avg;
    localparam int W   = 10;
    localparam int NCH = 3;

    typedef struct {
        int                   cyc;
        logic [NCH*W-1:0]     dat;
        logic [NCH-1:0]       oflag;
    } ent_t;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b0;
    logic               IN_VALID = 1'b0;
    logic [NCH*W-1:0]   IN_DATA = '0;
    logic               CLR = 1'b0;
    logic               MODE = 1'b0;
    logic               vld   [2];
    logic [NCH*W-1:0]   dat   [2];
    logic [NCH-1:0]     oflag [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int               msum [2][NCH];
    int               mcnt [2];
    bit               pv   [2];
    int               pavg [2][NCH];
    logic             ev   [2];
    logic [NCH*W-1:0] ed   [2];
    logic [NCH-1:0]   eo   [2];

    ent_t lg0[$];
    ent_t lg1[$];

    axis_mag_avg #(.WIDTH(W), .NCH(NCH), .AVG_LOG2(2)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .CLR(CLR), .MODE(MODE), .OUT_VALID(vld[0]), .OUT_DATA(dat[0]), .OUT_OVF(oflag[0])
    );

    axis_mag_avg #(.WIDTH(W), .NCH(NCH), .AVG_LOG2(0)) u_dut_single (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .CLR(CLR), .MODE(MODE), .OUT_VALID(vld[1]), .OUT_DATA(dat[1]), .OUT_OVF(oflag[1])
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    function automatic int win_len(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int fdiv(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    function automatic int smp(input int c);
        logic signed [W-1:0] s;
        s = IN_DATA[c*W +: W];
        return int'(s);
    endfunction

    function automatic void enc(input int a, input bit mode, output logic [W-1:0] d, output logic o);
        o = 1'b0;
        if (mode || a >= 0) d = W'(a);
        else if (a == -(1 << (W-1))) begin
            d = '1;
            o = 1'b1;
        end else d = W'((1 << (W-1)) - a);
    endfunction

    function automatic void reset_model();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            pv[k] = 1'b0;
            ev[k] = 1'b0;
            ed[k] = '0;
            eo[k] = '0;
            for (int c = 0; c < NCH; c++) begin
                msum[k][c] = 0;
                pavg[k][c] = 0;
            end
        end
    endfunction

    // Reference model: accumulate plain integer sums, divide with floor at window end,
    // and present the encoded result one clock after the accepting edge.
    initial begin
        logic [W-1:0] dd;
        logic         oo;
        reset_model();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) reset_model();
            else begin
                for (int k = 0; k < 2; k++) begin
                    ev[k] = pv[k] && !CLR;
                    if (ev[k]) begin
                        for (int c = 0; c < NCH; c++) begin
                            enc(pavg[k][c], MODE, dd, oo);
                            ed[k][c*W +: W] = dd;
                            eo[k][c] = oo;
                        end
                    end
                    pv[k] = 1'b0;
                    if (CLR) begin
                        mcnt[k] = 0;
                        for (int c = 0; c < NCH; c++) msum[k][c] = 0;
                    end else if (IN_VALID) begin
                        for (int c = 0; c < NCH; c++) msum[k][c] += smp(c);
                        mcnt[k]++;
                        if (mcnt[k] == win_len(k)) begin
                            for (int c = 0; c < NCH; c++) begin
                                pavg[k][c] = fdiv(msum[k][c], win_len(k));
                                msum[k][c] = 0;
                            end
                            pv[k] = 1'b1;
                            mcnt[k] = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        ent_t e;
        forever begin
            @(negedge CLK);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("out_valid%0d", k), vld[k], ev[k]);
                chk($sformatf("out_data%0d", k), dat[k], ed[k]);
                chk($sformatf("out_ovf%0d", k), oflag[k], eo[k]);
                if (vld[k] === 1'b1) begin
                    e.cyc = cyc;
                    e.dat = dat[k];
                    e.oflag = oflag[k];
                    if (k == 0) lg0.push_back(e);
                    else lg1.push_back(e);
                end
            end
        end
    end

    task automatic drv(input bit v, input int c0, input int c1, input int c2,
                       input bit clr, input bit mode);
        @(negedge CLK);
        #1;
        IN_VALID = v;
        IN_DATA  = {W'(c2), W'(c1), W'(c0)};
        CLR      = clr;
        MODE     = mode;
    endtask

    task automatic idle(input int n, input bit mode);
        for (int i = 0; i < n; i++) drv(1'b0, 0, 0, 0, 1'b0, mode);
    endtask

    initial begin
        int last_cyc;
        int r;
        bit v, cl, md;
        int d [NCH];

        repeat (3) @(negedge CLK);
        chk("reset_valid", vld[0], 1'b0);
        chk("reset_data", dat[0], '0);
        chk("reset_ovf", oflag[0], '0);
        #1 RST_N = 1'b1;

        // -3 on ch0, 1/2/2/2 on ch1, sum -5 on ch2, sign-magnitude
        lg0.delete();
        drv(1, -3, 1, -1, 0, 0);
        drv(1, -3, 2, -1, 0, 0);
        drv(1, -3, 2, -1, 0, 0);
        drv(1, -3, 2, -2, 0, 0);
        last_cyc = cyc;
        idle(4, 0);
        chk("avg_pulses", lg0.size(), 1);
        if (lg0.size() == 1) begin
            chk("avg_latency", lg0[0].cyc, last_cyc + 2);
            chk("avg_ch0", lg0[0].dat[W-1:0], 10'h203);
            chk("avg_ch1", lg0[0].dat[2*W-1:W], 10'h001);
            chk("avg_ch2", lg0[0].dat[3*W-1:2*W], 10'h202);
            chk("avg_ovf", lg0[0].oflag, 3'b000);
        end
        chk("model_ch2", ed[0][3*W-1:2*W], 10'h202);

        // Most negative average: saturates in mode 0, passes through in mode 1
        lg0.delete();
        repeat (4) drv(1, -512, 0, 0, 0, 0);
        idle(4, 0);
        chk("sat_pulses", lg0.size(), 1);
        if (lg0.size() == 1) begin
            chk("sat_ch0", lg0[0].dat[W-1:0], 10'h3FF);
            chk("sat_ovf0", lg0[0].oflag[0], 1'b1);
        end
        chk("model_sat", ed[0][W-1:0], 10'h3FF);
        lg0.delete();
        repeat (4) drv(1, -512, 0, 0, 0, 1);
        idle(4, 1);
        chk("pass_pulses", lg0.size(), 1);
        if (lg0.size() == 1) begin
            chk("pass_ch0", lg0[0].dat[W-1:0], 10'h200);
            chk("pass_ovf0", lg0[0].oflag[0], 1'b0);
        end

        // Clear in the middle of a window, with a coincident sample that must be dropped
        lg0.delete();
        drv(1, 3, 3, 3, 0, 0);
        drv(1, 3, 3, 3, 0, 0);
        drv(1, 9, 9, 9, 1, 0);
        drv(0, 0, 0, 0, 0, 0);
        chk("clr_hold", dat[0][W-1:0], 10'h200);
        repeat (4) drv(1, 5, 5, 5, 0, 0);
        idle(4, 0);
        chk("clr_pulses", lg0.size(), 1);
        if (lg0.size() == 1) chk("clr_ch0", lg0[0].dat[W-1:0], 10'h005);

        // Window of one: back-to-back samples give back-to-back outputs
        lg1.delete();
        drv(1, -1, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0);
        idle(4, 0);
        chk("single_pulses", lg1.size(), 3);
        if (lg1.size() == 3) begin
            chk("single_v0", lg1[0].dat[W-1:0], 10'h201);
            chk("single_v1", lg1[1].dat[W-1:0], 10'h000);
            chk("single_v2", lg1[2].dat[W-1:0], 10'h001);
            chk("single_gap1", lg1[1].cyc, lg1[0].cyc + 1);
            chk("single_gap2", lg1[2].cyc, lg1[1].cyc + 1);
        end
        drv(0, 0, 0, 0, 1, 0);

        // Asynchronous reset after three samples of a window
        repeat (3) drv(1, 9, 9, 9, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_valid", vld[0], 1'b0);
        chk("arst_data", dat[0], '0);
        chk("arst_ovf", oflag[0], '0);
        chk("arst_data1", dat[1], '0);
        idle(2, 0);
        RST_N = 1'b1;
        lg0.delete();
        repeat (4) drv(1, 7, 7, 7, 0, 0);
        idle(4, 0);
        chk("arst_pulses", lg0.size(), 1);
        if (lg0.size() == 1) chk("arst_ch0", lg0[0].dat[W-1:0], 10'h007);

        // Randomised traffic, with stretches biased towards the extremes
        r = 0;
        md = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) r = $urandom_range(0, 2);
            v  = ($urandom_range(0, 99) < 75);
            cl = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) md = ~md;
            for (int c = 0; c < NCH; c++) begin
                if (r == 1 && $urandom_range(0, 3) != 0) d[c] = -512;
                else if (r == 2) d[c] = ($urandom_range(0, 1) == 1) ? 511 : -511;
                else d[c] = int'($urandom_range(0, 1023)) - 512;
            end
            drv(v, d[0], d[1], d[2], cl, md);
        end
        idle(4, md);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
